// File: rtl/gold_seq_pkg.sv
// Shared definitions for the Gold sequence generator: default LFSR taps, warm-up
// offset, x1 seed and the controller state encoding.
package gold_seq_pkg;

    localparam logic [30:0] X1_TAPS_DEFAULT = 31'h0000_0009;
    localparam logic [30:0] X2_TAPS_DEFAULT = 31'h0000_000F;
    localparam int          NC_DEFAULT      = 1600;
    localparam logic [30:0] X1_INIT         = 31'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/lfsr_step_n.sv
// Combinational multi-step advance of one Fibonacci LFSR (bit 0 oldest, feedback into MSB).
// Also returns the bits shifted out, oldest first, so callers get x(n)..x(n+STEPS-1).
module lfsr_step_n #(
    parameter int               WIDTH = 31,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(9),
    parameter int               STEPS = 1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt,
    output logic [STEPS-1:0] bits
);

    logic [WIDTH-1:0] acc;

    always_comb begin
        acc  = cur;
        bits = '0;
        for (int s = 0; s < STEPS; s++) begin
            bits[s] = acc[0];
            acc     = {^(acc & TAPS), acc[WIDTH-1:1]};
        end
        nxt = acc;
    end

endmodule

// File: rtl/gold_seq_gen_par.sv
// Gold sequence generator c(n) = x1(n+NC) ^ x2(n+NC), BITS_PER_CLK bits per valid/ready beat.
// Define GOLD_OFFSET_EN to add start_offset, which lengthens warm-up by floor(start_offset/B) beats.
module gold_seq_gen_par
    import gold_seq_pkg::*;
#(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] X1_TAPS      = LFSR_WIDTH'(X1_TAPS_DEFAULT),
    parameter logic [LFSR_WIDTH-1:0] X2_TAPS      = LFSR_WIDTH'(X2_TAPS_DEFAULT),
    parameter int                    NC           = NC_DEFAULT,
    parameter int                    BITS_PER_CLK = 1,
    parameter int                    LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LFSR_WIDTH-1:0]   cinit,
    input  logic [LEN_WIDTH-1:0]    seq_len,
`ifdef GOLD_OFFSET_EN
    input  logic [LEN_WIDTH-1:0]    start_offset,
`endif
    output logic [BITS_PER_CLK-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int          B         = BITS_PER_CLK;
    localparam logic [31:0] B_U       = 32'(BITS_PER_CLK);
    localparam logic [31:0] WARM_BASE = 32'(NC / BITS_PER_CLK);

    // Handshake: a beat transfers on a rising clk edge where out_valid && out_ready.
    // out_data/out_last depend only on registered state, so they hold while stalled.

    state_t                  state;
    state_t                  state_nxt;
    logic [LFSR_WIDTH-1:0]   x1;
    logic [LFSR_WIDTH-1:0]   x2;
    logic [LFSR_WIDTH-1:0]   x1_adv;
    logic [LFSR_WIDTH-1:0]   x2_adv;
    logic [B-1:0]            bits1;
    logic [B-1:0]            bits2;
    logic [B-1:0]            tail_mask;
    logic [LEN_WIDTH-1:0]    rem;
    logic [31:0]             rem32;
    logic [31:0]             warm_cnt;
    logic [31:0]             warm_total;
    logic                    load;
    logic                    adv;
    logic                    fire;

    lfsr_step_n #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (X1_TAPS),
        .STEPS (B)
    ) u_x1_step (
        .cur  (x1),
        .nxt  (x1_adv),
        .bits (bits1)
    );

    lfsr_step_n #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (X2_TAPS),
        .STEPS (B)
    ) u_x2_step (
        .cur  (x2),
        .nxt  (x2_adv),
        .bits (bits2)
    );

`ifdef GOLD_OFFSET_EN
    assign warm_total = WARM_BASE + 32'(start_offset / LEN_WIDTH'(B));
`else
    assign warm_total = WARM_BASE;
`endif

    assign rem32     = 32'(rem);
    assign fire      = out_valid & out_ready;
    assign out_valid = (state == RUN);
    assign out_last  = (state == RUN) && (rem32 <= B_U);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Bits at or beyond the remaining count are zeroed on the final, partial beat.
    always_comb begin
        tail_mask = '0;
        for (int i = 0; i < B; i++) begin
            tail_mask[i] = (32'(i) < rem32);
        end
    end

    assign out_data = (state == RUN) ? ((bits1 ^ bits2) & tail_mask) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (seq_len == '0) begin
                        state_nxt = DONE;
                    end else if (warm_total == 32'd0) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = WARMUP;
                    end
                end
            end
            WARMUP: begin
                adv = 1'b1;
                if (warm_cnt == 32'd1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    adv = 1'b1;
                    if (out_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1       <= '0;
            x2       <= '0;
            rem      <= '0;
            warm_cnt <= '0;
        end else if (load) begin
            x1       <= LFSR_WIDTH'(X1_INIT);
            x2       <= cinit;
            rem      <= seq_len;
            warm_cnt <= warm_total;
        end else if (adv) begin
            x1 <= x1_adv;
            x2 <= x2_adv;
            if (state == WARMUP) begin
                warm_cnt <= warm_cnt - 32'd1;
            end else if (out_last) begin
                rem <= '0;
            end else begin
                rem <= rem - LEN_WIDTH'(B);
            end
        end
    end

endmodule

// File: tb/tb_gold_seq_gen_par.sv
// Randomized bench for gold_seq_gen_par (B=4, NC=1600) against an array-based Gold sequence model.
// Offset scenarios are added when GOLD_OFFSET_EN is defined.
module tb_gold_seq_gen_par;

    localparam int          B  = 4;
    localparam int          NC = 1600;
    localparam int          W  = 31;
    localparam logic [30:0] X1_MASK = 31'h0000_0009;
    localparam logic [30:0] X2_MASK = 31'h0000_000F;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [30:0]  cinit;
    logic [15:0]  seq_len;
`ifdef GOLD_OFFSET_EN
    logic [15:0]  start_offset;
`endif
    logic [B-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         done;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [B-1:0] exp_q[$];
    bit           exp_last_q[$];

    always #5 clk = ~clk;

    gold_seq_gen_par #(
        .LFSR_WIDTH   (31),
        .X1_TAPS      (31'h0000_0009),
        .X2_TAPS      (31'h0000_000F),
        .NC           (NC),
        .BITS_PER_CLK (B),
        .LEN_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cinit        (cinit),
        .seq_len      (seq_len),
`ifdef GOLD_OFFSET_EN
        .start_offset (start_offset),
`endif
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: x(n+31) = XOR of x(n+k) over set mask bits k; c(m) = x1(warm+m) ^ x2(warm+m).
    task automatic build_exp(input logic [30:0] ci, input int len, input int off);
        int           warm;
        int           tot;
        int           nb;
        int           m;
        bit           x1[];
        bit           x2[];
        bit           f1;
        bit           f2;
        logic [30:0]  m1;
        logic [30:0]  m2;
        logic [B-1:0] beat;
        m1   = X1_MASK;
        m2   = X2_MASK;
        warm = NC + (off / B) * B;
        tot  = warm + len + W;
        x1   = new[tot];
        x2   = new[tot];
        for (int k = 0; k < W; k++) begin
            x1[k] = (k == 0);
            x2[k] = ci[k];
        end
        for (int n = 0; n + W < tot; n++) begin
            f1 = 1'b0;
            f2 = 1'b0;
            for (int k = 0; k < W; k++) begin
                if (m1[k]) f1 ^= x1[n+k];
                if (m2[k]) f2 ^= x2[n+k];
            end
            x1[n+W] = f1;
            x2[n+W] = f2;
        end
        exp_q.delete();
        exp_last_q.delete();
        nb = (len + B - 1) / B;
        for (int j = 0; j < nb; j++) begin
            beat = '0;
            for (int i = 0; i < B; i++) begin
                m = j * B + i;
                if (m < len) beat[i] = x1[warm+m] ^ x2[warm+m];
            end
            exp_q.push_back(beat);
            exp_last_q.push_back(j == nb - 1);
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 3 cycles at beat 3.
    task automatic run_seq(input logic [30:0] ci, input int len, input int off,
                           input int mode, input bit poke);
        int  cyc;
        int  first_cyc;
        int  beats;
        int  exp_done;
        int  stall_left;
        int  bound;
        int  nb;
        bit  seen_done;
        bit  stalled;
        bit  poked;
        bit  r;
        build_exp(ci, len, off);
        nb         = exp_q.size();
        bound      = NC / B + off / B + nb * 8 + 40;
        cyc        = 0;
        first_cyc  = -1;
        beats      = 0;
        exp_done   = (len == 0) ? 1 : -1;
        stall_left = 0;
        seen_done  = 1'b0;
        stalled    = 1'b0;
        poked      = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        cinit     = ci;
        seq_len   = len[15:0];
`ifdef GOLD_OFFSET_EN
        start_offset = off[15:0];
`endif
        out_ready = 1'b1;
        while (!seen_done && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (cyc == 1) check_eq("busy_after_start", busy, 1);
            if (done) begin
                seen_done = 1'b1;
                check_eq("done_cycle", cyc, exp_done);
                check_eq("valid_at_done", out_valid, 0);
            end
            if (out_valid) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check_eq("first_valid_cycle", cyc, NC / B + off / B + 1);
                end
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", out_valid, 0);
                end else begin
                    check_eq("data", out_data, exp_q[0]);
                    check_eq("last", out_last, exp_last_q[0]);
                    r = 1'b1;
                    if (mode == 1) r = 1'($urandom_range(0, 1));
                    if (mode == 2) begin
                        if (beats == 2 && !stalled) begin
                            stalled    = 1'b1;
                            stall_left = 3;
                        end
                        if (stall_left > 0) begin
                            r = 1'b0;
                            stall_left--;
                        end
                    end
                    if (poke && beats == 1 && !poked) begin
                        poked   = 1'b1;
                        start   = 1'b1;
                        cinit   = ~ci;
                        seq_len = 16'd5;
                    end
                    out_ready = r;
                    if (r) begin
                        if (exp_last_q[0]) exp_done = cyc + 1;
                        void'(exp_q.pop_front());
                        void'(exp_last_q.pop_front());
                        beats++;
                    end
                end
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        check_eq("done_seen", seen_done, 1);
        check_eq("beat_count", beats, nb);
        check_eq("exp_left", exp_q.size(), 0);
        @(posedge clk); #1;
        check_eq("idle_busy", busy, 0);
        check_eq("done_one_cycle", done, 0);
    endtask

    task automatic reset_mid_run(input logic [30:0] ci, input int len);
        int cyc;
        int beats;
        bit reached;
        cyc     = 0;
        beats   = 0;
        reached = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        cinit     = ci;
        seq_len   = len[15:0];
`ifdef GOLD_OFFSET_EN
        start_offset = 16'd0;
`endif
        out_ready = 1'b1;
        while (!reached && cyc < NC / B + 40) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (out_valid) begin
                if (beats == 2) reached = 1'b1;
                else beats++;
            end
        end
        check_eq("reached_beat3", reached, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_done", done, 0);
        check_eq("post_rst_busy", busy, 0);
        run_seq(ci, len, 0, 0, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        cinit     = '0;
        seq_len   = '0;
        out_ready = 1'b0;
`ifdef GOLD_OFFSET_EN
        start_offset = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_data", out_data, 0);
        check_eq("reset_last", out_last, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        rst = 1'b1;

        run_seq(31'h1234, 64, 0, 0, 1'b0);
        run_seq(31'($urandom), 5, 0, 0, 1'b0);
        run_seq(31'($urandom), 37, 0, 2, 1'b0);
        run_seq(31'($urandom), 0, 0, 0, 1'b0);
        run_seq(31'($urandom), 24, 0, 0, 1'b1);
        reset_mid_run(31'h1234, 40);
        for (int t = 0; t < 6; t++) begin
            run_seq(31'($urandom), int'($urandom_range(1, 80)), 0, 1, 1'b0);
        end
`ifdef GOLD_OFFSET_EN
        run_seq(31'h1234, 64, 864, 0, 1'b0);
        run_seq(31'($urandom), 23, int'($urandom_range(0, 100)), 1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gold_seq_gen_par.md
Name: gold_seq_gen_par

Overview:
Parametrised 3GPP-style Gold sequence generator (TS 38.211 §5.2.1): c(n) = x1(n+NC) XOR x2(n+NC).
- Two internal LFSRs: x1 has a fixed seed, x2 is seeded from cinit.
- Automatic NC-step warm-up.
- Emits BITS_PER_CLK scrambling bits per beat over a valid/ready stream.
- Serves PBCH/DMRS scrambling in the post-FFT chain and supersedes the single-bit, externally sequenced LFSR.

Parameters:
LFSR_WIDTH, 31, register width of both LFSRs
X1_TAPS, 31'h0000_0009, x1 feedback mask; bit k set means x(n+k) is XORed into x(n+LFSR_WIDTH)
X2_TAPS, 31'h0000_000F, x2 feedback mask, same convention
NC, 1600, warm-up offset in bits; must be a multiple of BITS_PER_CLK
BITS_PER_CLK, 1, output bits per beat, 1..32
LEN_WIDTH, 16, width of the sequence-length field

Ports:
clk        in   1               clock
rst        in   1               asynchronous active-low reset
start      in   1               single-cycle request pulse; sampled only in IDLE
cinit      in   LFSR_WIDTH      x2 seed, captured on accepted start
seq_len    in   LEN_WIDTH       number of output bits, captured on accepted start
out_data   out  BITS_PER_CLK    bit i = c(n+i)
out_valid  out  1               out_data valid
out_ready  in   1               downstream accept
out_last   out  1               final beat of the sequence
busy       out  1               high in every state except IDLE
done       out  1               one-cycle pulse at completion

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; both LFSRs = 0; remaining count = 0.
  - out_data, out_valid, out_last, busy and done all = 0.
  - Asserting reset mid-operation aborts immediately; no done pulse is produced.
- LFSR convention:
  - Bit 0 is the oldest bit, x(n).
  - One step = shift right, with feedback = ^(TAPS & reg) entering the MSB.
  - B steps are unrolled combinationally per clock, where B = BITS_PER_CLK.
- States:
  - IDLE: on start, x1 <= 1 (bit0 = 1, others 0), x2 <= cinit, rem <= seq_len. If seq_len = 0, go to DONE; otherwise go to WARMUP.
  - WARMUP: both LFSRs advance B steps per cycle for exactly NC/B cycles, then go to RUN. out_valid = 0.
  - RUN:
    - out_valid = 1; out_data[i] = x1[i] ^ x2[i] for i < B.
    - On out_valid & out_ready: LFSRs advance B steps and rem -= min(rem, B).
    - out_last = (rem <= B).
    - On the last beat, bits i >= rem are driven 0.
    - A handshake while out_last = 1 goes to DONE.
  - DONE: done = 1 for one cycle, then return to IDLE.
- Latency: with start accepted at cycle 0, the first out_valid appears at cycle NC/B + 1.
- Backpressure: while out_valid & !out_ready, out_data and out_last are held stable and the LFSRs are frozen.
- start while busy is ignored; cinit and seq_len are not re-sampled.
- Beat count per sequence: ceil(seq_len/B).
- Output is registered from LFSR state. There is no combinational path from out_ready to out_data.

Optional Feature:
Macro: GOLD_OFFSET_EN
- Defined:
  - Adds input start_offset [LEN_WIDTH-1:0], captured with start.
  - Warm-up length becomes NC + (start_offset rounded down to a multiple of B) bits, i.e. NC/B + floor(start_offset/B) cycles.
  - Used for the PBCH v·M_bit scrambling offset.
- Undefined: the port is absent and warm-up is exactly NC/B cycles.

Decomposition:
- Package gold_seq_pkg:
  - Default X1_TAPS/X2_TAPS, NC_DEFAULT = 1600, X1_INIT = 31'd1.
  - State enum (IDLE, WARMUP, RUN, DONE).
- Sub-module lfsr_step_n:
  - Combinational B-step advance of one LFSR, with parameters WIDTH, TAPS and STEPS.
  - Instantiated twice, for x1 and x2.

Test Plan:
- Latency: B=8, NC=1600, cinit=31'h1234, seq_len=64, out_ready=1 → first out_valid at cycle 201; 8 beats; out_last on beat 8; done one cycle later; bits match the golden C model.
- Partial beat: B=4, seq_len=5 → 2 beats; beat 2 out_data[3:1] = 0, out_last = 1; total of 5 valid bits match the model.
- Backpressure: out_ready low for 3 cycles mid-RUN → out_data and out_last are constant, no beats are lost, and the stream still matches the model.
- Zero length and busy start: seq_len=0 → done pulses at cycle 1 with no out_valid. A second start during RUN is ignored and the cinit change has no effect.
- Reset mid-RUN: rst low at beat 3 → all outputs 0 at once; a new start with the same cinit reproduces the sequence from bit 0.
- GOLD_OFFSET_EN: start_offset=864, B=1 → output equals the unoffset sequence shifted by 864 bits.
